// File: rtl/fpnew_rob_wrapper_if.sv
// Issue, FPU and in-order response bundle for fpnew_rob_wrapper.
// slave = wrapper view; master = issuer/FPU environment view.
interface fpnew_rob_wrapper_if #(
    parameter int FLEN         = 64,
    parameter int NUM_OPERANDS = 3,
    parameter int CTRL_BITS    = 16,
    parameter int TAG_WIDTH    = 4,
    parameter int DEPTH        = 4
);
    localparam int IDXW = $clog2(DEPTH);
    localparam int FTW  = IDXW + 1;

    logic                         req_valid_i;
    logic                         req_ready_o;
    logic [NUM_OPERANDS*FLEN-1:0] req_operands_i;
    logic [CTRL_BITS-1:0]         req_ctrl_i;
    logic [TAG_WIDTH-1:0]         req_tag_i;
    logic                         flush_i;

    logic                         fpu_valid_o;
    logic                         fpu_ready_i;
    logic [NUM_OPERANDS*FLEN-1:0] fpu_operands_o;
    logic [CTRL_BITS-1:0]         fpu_ctrl_o;
    logic [FTW-1:0]               fpu_tag_o;
    logic                         fpu_flush_o;

    logic                         fpu_rsp_valid_i;
    logic                         fpu_rsp_ready_o;
    logic [FLEN-1:0]              fpu_result_i;
    logic [4:0]                   fpu_status_i;
    logic [FTW-1:0]               fpu_tag_i;

    logic                         rsp_valid_o;
    logic                         rsp_ready_i;
    logic [FLEN-1:0]              rsp_result_o;
    logic [4:0]                   rsp_status_o;
    logic [TAG_WIDTH-1:0]         rsp_tag_o;

    logic [4:0]                   fflags_o;
    logic                         fflags_clr_i;
    logic [IDXW:0]                count_o;
    logic                         busy_o;
    logic                         err_o;

    modport slave (
        input  req_valid_i, req_operands_i, req_ctrl_i, req_tag_i, flush_i,
        output req_ready_o,
        output fpu_valid_o, fpu_operands_o, fpu_ctrl_o, fpu_tag_o, fpu_flush_o,
        input  fpu_ready_i,
        input  fpu_rsp_valid_i, fpu_result_i, fpu_status_i, fpu_tag_i,
        output fpu_rsp_ready_o,
        output rsp_valid_o, rsp_result_o, rsp_status_o, rsp_tag_o,
        input  rsp_ready_i,
        output fflags_o, count_o, busy_o, err_o,
        input  fflags_clr_i
    );

    modport master (
        output req_valid_i, req_operands_i, req_ctrl_i, req_tag_i, flush_i,
        input  req_ready_o,
        input  fpu_valid_o, fpu_operands_o, fpu_ctrl_o, fpu_tag_o, fpu_flush_o,
        output fpu_ready_i,
        output fpu_rsp_valid_i, fpu_result_i, fpu_status_i, fpu_tag_i,
        input  fpu_rsp_ready_o,
        input  rsp_valid_o, rsp_result_o, rsp_status_o, rsp_tag_o,
        output rsp_ready_i,
        input  fflags_o, count_o, busy_o, err_o,
        output fflags_clr_i
    );
endinterface

// File: rtl/fpnew_rob_wrapper.sv
// In-order completion ROB around an out-of-order FPnew; issue path 0 cycles, FPU result to rsp 1 cycle.
// Backpressure: req stalls when the ROB is full or the FPU stalls; rsp holds the head entry until popped.
module fpnew_rob_wrapper #(
    parameter int FLEN         = 64,
    parameter int NUM_OPERANDS = 3,
    parameter int CTRL_BITS    = 16,
    parameter int TAG_WIDTH    = 4,
    parameter int DEPTH        = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    fpnew_rob_wrapper_if.slave   bus
);
    localparam int IDXW = $clog2(DEPTH);
    localparam int CW   = IDXW + 1;

    typedef struct packed {
        logic [TAG_WIDTH-1:0] utag;
        logic [FLEN-1:0]      result;
        logic [4:0]           status;
    } rob_dat_t;

    logic [DEPTH-1:0] alloc_q;
    logic [DEPTH-1:0] done_q;
    rob_dat_t         dat_q [DEPTH];
    logic [IDXW-1:0]  head_q;
    logic [IDXW-1:0]  tail_q;
    logic [CW-1:0]    count_q;
    logic             epoch_q;
    logic [4:0]       fflags_q;
    logic             err_q;

    logic            full;
    logic            alloc_fire;
    logic            pop;
    logic            rsp_vld;
    logic [IDXW-1:0] rsp_slot;
    logic            rsp_epoch_ok;
    logic            rsp_hit;
    logic            rsp_err;

    assign full       = (count_q == CW'(DEPTH));
    assign alloc_fire = bus.req_valid_i & bus.req_ready_o;

    assign bus.fpu_valid_o    = bus.req_valid_i & ~full & ~bus.flush_i;
    assign bus.req_ready_o    = bus.fpu_ready_i & ~full & ~bus.flush_i;
    assign bus.fpu_operands_o = bus.req_operands_i;
    assign bus.fpu_ctrl_o     = bus.req_ctrl_i;
    assign bus.fpu_tag_o      = {epoch_q, tail_q};
    assign bus.fpu_flush_o    = bus.flush_i;
    assign bus.fpu_rsp_ready_o = 1'b1;

    // Stale-epoch responses belong to ops killed by a flush and vanish quietly;
    // a current-epoch response to a free slot is a protocol error.
    assign rsp_slot     = bus.fpu_tag_i[IDXW-1:0];
    assign rsp_epoch_ok = (bus.fpu_tag_i[IDXW] == epoch_q);
    assign rsp_hit      = bus.fpu_rsp_valid_i & ~bus.flush_i & rsp_epoch_ok & alloc_q[rsp_slot];
    assign rsp_err      = bus.fpu_rsp_valid_i & ~bus.flush_i & rsp_epoch_ok & ~alloc_q[rsp_slot];

    assign rsp_vld          = (count_q != '0) & done_q[head_q] & ~bus.flush_i;
    assign pop              = rsp_vld & bus.rsp_ready_i;
    assign bus.rsp_valid_o  = rsp_vld;
    assign bus.rsp_result_o = dat_q[head_q].result;
    assign bus.rsp_status_o = dat_q[head_q].status;
    assign bus.rsp_tag_o    = dat_q[head_q].utag;

    assign bus.fflags_o = fflags_q;
    assign bus.count_o  = count_q;
    assign bus.busy_o   = (count_q != '0);
    assign bus.err_o    = err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            alloc_q  <= '0;
            done_q   <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            epoch_q  <= 1'b0;
            fflags_q <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            // A clear loses to a coincident pop so that pop's flags are not lost.
            if (bus.fflags_clr_i) begin
                fflags_q <= pop ? dat_q[head_q].status : 5'b0;
            end else if (pop) begin
                fflags_q <= fflags_q | dat_q[head_q].status;
            end
            if (rsp_err) begin
                err_q <= 1'b1;
            end

            if (bus.flush_i) begin
                alloc_q <= '0;
                done_q  <= '0;
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
                epoch_q <= ~epoch_q;
            end else begin
                if (rsp_hit) begin
                    done_q[rsp_slot]        <= 1'b1;
                    dat_q[rsp_slot].result  <= bus.fpu_result_i;
                    dat_q[rsp_slot].status  <= bus.fpu_status_i;
                end
                if (alloc_fire) begin
                    alloc_q[tail_q]    <= 1'b1;
                    done_q[tail_q]     <= 1'b0;
                    dat_q[tail_q].utag <= bus.req_tag_i;
                    tail_q             <= tail_q + IDXW'(1);
                end
                if (pop) begin
                    alloc_q[head_q] <= 1'b0;
                    done_q[head_q]  <= 1'b0;
                    head_q          <= head_q + IDXW'(1);
                end
                count_q <= count_q + CW'(alloc_fire) - CW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_fpnew_rob_wrapper.sv
// Directed bench for fpnew_rob_wrapper: stimulus pushes expected responses, a monitor checks rsp_* in order.
module tb_fpnew_rob_wrapper;
    localparam int FLEN  = 64;
    localparam int NOP   = 3;
    localparam int CB    = 16;
    localparam int TW    = 4;
    localparam int DEPTH = 4;
    localparam int FTW   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fpnew_rob_wrapper_if #(.FLEN(FLEN), .NUM_OPERANDS(NOP), .CTRL_BITS(CB),
                           .TAG_WIDTH(TW), .DEPTH(DEPTH)) bus ();

    fpnew_rob_wrapper #(.FLEN(FLEN), .NUM_OPERANDS(NOP), .CTRL_BITS(CB),
                        .TAG_WIDTH(TW), .DEPTH(DEPTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic [TW-1:0]   tag;
        logic [FLEN-1:0] res;
        logic [4:0]      st;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rsp(input logic [TW-1:0] tag, input logic [FLEN-1:0] res, input logic [4:0] st);
        exp_t e;
        e.tag = tag;
        e.res = res;
        e.st  = st;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [TW-1:0] tag, input logic [FTW-1:0] ftag);
        logic [191:0] ops;
        logic [15:0]  ctl;
        ops = {60'h0, tag, 64'hDEAD_BEEF_0000_0001, 60'hCAFE, tag};
        ctl = {12'hABC, tag};
        bus.req_valid_i    = 1'b1;
        bus.req_tag_i      = tag;
        bus.req_operands_i = ops;
        bus.req_ctrl_i     = ctl;
        #1;
        check("issue_ready", bus.req_ready_o, 1);
        check("issue_fpu_valid", bus.fpu_valid_o, 1);
        check("issue_fpu_tag", bus.fpu_tag_o, ftag);
        check("issue_operands", bus.fpu_operands_o, ops);
        check("issue_ctrl", bus.fpu_ctrl_o, ctl);
        tick();
        bus.req_valid_i = 1'b0;
    endtask

    task automatic fpu_ret(input logic [FTW-1:0] ftag, input logic [FLEN-1:0] res, input logic [4:0] st);
        bus.fpu_rsp_valid_i = 1'b1;
        bus.fpu_tag_i       = ftag;
        bus.fpu_result_i    = res;
        bus.fpu_status_i    = st;
        tick();
        bus.fpu_rsp_valid_i = 1'b0;
    endtask

    // Monitor: every cycle rsp_valid_o is up, rsp_* must equal the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.rsp_valid_o) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: got tag %0h result %0h, expected no response",
                             bus.rsp_tag_o, bus.rsp_result_o);
                end else begin
                    check("rsp_tag", bus.rsp_tag_o, sb[0].tag);
                    check("rsp_result", bus.rsp_result_o, sb[0].res);
                    check("rsp_status", bus.rsp_status_o, sb[0].st);
                    if (bus.rsp_ready_i) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time expired, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid_i     = 1'b0;
        bus.req_operands_i  = '0;
        bus.req_ctrl_i      = '0;
        bus.req_tag_i       = '0;
        bus.flush_i         = 1'b0;
        bus.fpu_ready_i     = 1'b1;
        bus.fpu_rsp_valid_i = 1'b0;
        bus.fpu_result_i    = '0;
        bus.fpu_status_i    = '0;
        bus.fpu_tag_i       = '0;
        bus.rsp_ready_i     = 1'b1;
        bus.fflags_clr_i    = 1'b0;

        // Reset values while reset is asserted
        #2;
        check("rst_rsp_valid", bus.rsp_valid_o, 0);
        check("rst_fflags", bus.fflags_o, 0);
        check("rst_count", bus.count_o, 0);
        check("rst_busy", bus.busy_o, 0);
        check("rst_err", bus.err_o, 0);
        check("rst_fpu_valid", bus.fpu_valid_o, 0);
        check("rst_req_ready", bus.req_ready_o, 1);
        check("rst_fpu_rsp_ready", bus.fpu_rsp_ready_o, 1);
        tick();
        rst = 1'b0;
        tick();

        // Basic out-of-order return, in-order response
        expect_rsp(4'd3, 64'hA, 5'h0);
        expect_rsp(4'd7, 64'hB, 5'h0);
        issue(4'd3, 3'd0);
        issue(4'd7, 3'd1);
        check("basic_count2", bus.count_o, 2);
        fpu_ret(3'd1, 64'hB, 5'h0);
        check("basic_head_wait", bus.rsp_valid_o, 0);
        fpu_ret(3'd0, 64'hA, 5'h0);
        check("basic_rsp0_valid", bus.rsp_valid_o, 1);
        check("basic_rsp0_tag", bus.rsp_tag_o, 3);
        tick();
        check("basic_rsp1_tag", bus.rsp_tag_o, 7);
        check("basic_count1", bus.count_o, 1);
        tick();
        check("basic_count0", bus.count_o, 0);
        check("basic_busy0", bus.busy_o, 0);

        // Re-home pointers with a short async reset
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();

        // Full
        expect_rsp(4'd1, 64'h10, 5'h0);
        expect_rsp(4'd2, 64'h20, 5'h0);
        expect_rsp(4'd4, 64'h40, 5'h0);
        expect_rsp(4'd5, 64'h50, 5'h0);
        issue(4'd1, 3'd0);
        issue(4'd2, 3'd1);
        issue(4'd4, 3'd2);
        issue(4'd5, 3'd3);
        check("full_count", bus.count_o, 4);
        check("full_ready", bus.req_ready_o, 0);
        bus.req_valid_i = 1'b1;
        #1;
        check("full_fpu_valid", bus.fpu_valid_o, 0);
        bus.req_valid_i = 1'b0;
        fpu_ret(3'd0, 64'h10, 5'h0);
        check("full_pop_valid", bus.rsp_valid_o, 1);
        check("full_no_bypass", bus.req_ready_o, 0);
        tick();
        check("full_ready_after_pop", bus.req_ready_o, 1);
        check("full_next_tag", bus.fpu_tag_o, 0);
        check("full_count3", bus.count_o, 3);
        expect_rsp(4'd6, 64'h60, 5'h0);
        issue(4'd6, 3'd0);
        fpu_ret(3'd3, 64'h50, 5'h0);
        fpu_ret(3'd1, 64'h20, 5'h0);
        fpu_ret(3'd2, 64'h40, 5'h0);
        fpu_ret(3'd0, 64'h60, 5'h0);
        tick();
        tick();
        tick();
        check("full_drained", bus.count_o, 0);

        // Flush
        issue(4'd8, 3'd1);
        issue(4'd9, 3'd2);
        issue(4'd10, 3'd3);
        check("flush_count3", bus.count_o, 3);
        bus.flush_i     = 1'b1;
        bus.req_valid_i = 1'b1;
        #1;
        check("flush_req_ready", bus.req_ready_o, 0);
        check("flush_fpu_valid", bus.fpu_valid_o, 0);
        check("flush_fwd", bus.fpu_flush_o, 1);
        tick();
        bus.flush_i     = 1'b0;
        bus.req_valid_i = 1'b0;
        #1;
        check("flush_count0", bus.count_o, 0);
        check("flush_next_tag", bus.fpu_tag_o, 4);
        fpu_ret(3'd1, 64'hBAD1, 5'h1f);
        fpu_ret(3'd2, 64'hBAD2, 5'h1f);
        check("flush_stale_err", bus.err_o, 0);
        check("flush_stale_count", bus.count_o, 0);
        check("flush_stale_valid", bus.rsp_valid_o, 0);

        // Backpressure: head held for 5 cycles while another op issues
        bus.rsp_ready_i = 1'b0;
        expect_rsp(4'd11, 64'h1234, 5'h0);
        expect_rsp(4'd12, 64'h5678, 5'h0);
        issue(4'd11, 3'd4);
        fpu_ret(3'd4, 64'h1234, 5'h0);
        issue(4'd12, 3'd5);
        check("bp_count2", bus.count_o, 2);
        fpu_ret(3'd5, 64'h5678, 5'h0);
        tick();
        tick();
        check("bp_valid_held", bus.rsp_valid_o, 1);
        check("bp_tag_held", bus.rsp_tag_o, 11);
        bus.rsp_ready_i = 1'b1;
        tick();
        tick();
        tick();
        check("bp_count0", bus.count_o, 0);

        // Sticky fflags and clear
        expect_rsp(4'd1, 64'h61, 5'h01);
        expect_rsp(4'd2, 64'h71, 5'h10);
        issue(4'd1, 3'd6);
        issue(4'd2, 3'd7);
        fpu_ret(3'd6, 64'h61, 5'h01);
        fpu_ret(3'd7, 64'h71, 5'h10);
        tick();
        tick();
        check("fflags_accum", bus.fflags_o, 5'h11);
        expect_rsp(4'd3, 64'h81, 5'h04);
        issue(4'd3, 3'd4);
        fpu_ret(3'd4, 64'h81, 5'h04);
        check("fflags_pop_ready", bus.rsp_valid_o, 1);
        bus.fflags_clr_i = 1'b1;
        tick();
        bus.fflags_clr_i = 1'b0;
        check("fflags_clr_with_pop", bus.fflags_o, 5'h04);
        check("fflags_count0", bus.count_o, 0);
        bus.fflags_clr_i = 1'b1;
        tick();
        bus.fflags_clr_i = 1'b0;
        check("fflags_clr_alone", bus.fflags_o, 5'h00);
        check("sb_empty", sb.size(), 0);

        // Error and reset mid-stream
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
        fpu_ret(3'd2, 64'hEE, 5'h0);
        check("err_free_slot", bus.err_o, 1);
        expect_rsp(4'd5, 64'hAA, 5'h0);
        issue(4'd5, 3'd0);
        issue(4'd6, 3'd1);
        bus.rsp_ready_i = 1'b0;
        fpu_ret(3'd0, 64'hAA, 5'h0);
        check("err_pre_rst_valid", bus.rsp_valid_o, 1);
        rst = 1'b1;
        #1;
        check("midrst_rsp_valid", bus.rsp_valid_o, 0);
        check("midrst_count", bus.count_o, 0);
        check("midrst_busy", bus.busy_o, 0);
        check("midrst_err", bus.err_o, 0);
        check("midrst_fflags", bus.fflags_o, 0);
        sb.delete();
        rst = 1'b0;
        bus.rsp_ready_i = 1'b1;
        tick();
        fpu_ret(3'd1, 64'hBB, 5'h0);
        check("late_rsp_err", bus.err_o, 1);
        check("late_rsp_valid", bus.rsp_valid_o, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
